// File: rtl/ncl_quad_bridge.sv
// ncl_quad_bridge: clocked bridge from binary operands to a 1-of-4 NCL adder and back.
// Optional watchdog compiled in with `define NCL_BRIDGE_TIMEOUT_EN.
module ncl_quad_bridge #(
  parameter int DIGITS         = 16,
  parameter int STABLE         = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DIGITS-1:0]   in_a,
  input  logic [2*DIGITS-1:0]   in_b,
  input  logic                  in_cin,
  output logic [4*DIGITS-1:0]   a_rail,
  output logic [4*DIGITS-1:0]   b_rail,
  output logic [1:0]            cin_rail,
  input  logic [4*DIGITS-1:0]   sum_rail,
  input  logic [1:0]            cout_rail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DIGITS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_err,
  output logic                  timeout
);
  localparam int W = 4*DIGITS+2;
  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_HOLD = 2'd2, S_NULL = 2'd3;
  logic [1:0]          r_state, w_next;
  logic                r_rdy;
  logic [2*DIGITS-1:0] r_a, r_b, w_dec;
  logic                r_cin;
  logic [W-1:0]        r_s1, r_s2, r_prev;
  logic [3:0]          r_cnt, w_run;
  logic [4*DIGITS-1:0] w_ea, w_eb;
  logic                w_drive, w_complete, w_multi, w_zero, w_good, w_done, w_wd_fire;

  assign w_drive  = (r_state == S_DATA) || (r_state == S_HOLD);
  assign a_rail   = w_drive ? w_ea : '0;
  assign b_rail   = w_drive ? w_eb : '0;
  assign cin_rail = w_drive ? (r_cin ? 2'b10 : 2'b01) : 2'b00;
  assign in_ready = r_rdy && (r_state == S_IDLE);

  // one-hot encode each registered operand digit onto its four rails
  always_comb begin
    w_ea = '0;
    w_eb = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_ea[4*i+:4] = 4'b0001 << r_a[2*i+:2];
      w_eb[4*i+:4] = 4'b0001 << r_b[2*i+:2];
    end
  end

  // decode the synchronized sum: lowest high rail wins, multiple high rails flag an error
  always_comb begin
    w_dec      = '0;
    w_complete = |r_s2[W-1-:2];
    w_multi    = &r_s2[W-1-:2];
    for (int i = 0; i < DIGITS; i++) begin
      w_dec[2*i+:2] = r_s2[4*i] ? 2'd0 : r_s2[4*i+1] ? 2'd1 : r_s2[4*i+2] ? 2'd2 : 2'd3;
      w_complete    = w_complete & (|r_s2[4*i+:4]);
      w_multi       = w_multi | ((r_s2[4*i+:4] & (r_s2[4*i+:4] - 4'd1)) != 4'd0);
    end
  end

  assign w_zero = (r_s2 == '0);
  assign w_good = (r_state == S_DATA) ? w_complete : (r_state == S_NULL) && w_zero;
  assign w_run  = !w_good ? 4'd0 : ((r_s2 == r_prev) && (r_cnt != 4'd0)) ? r_cnt + 4'd1 : 4'd1;
  assign w_done = w_run >= 4'(STABLE);

  // next state; a watchdog expiry overrides every other transition
  always_comb begin
    w_next = w_wd_fire ? S_IDLE :
             (r_state == S_IDLE) ? ((in_valid && in_ready) ? S_DATA : S_IDLE) :
             (r_state == S_DATA) ? (w_done ? S_HOLD : S_DATA) :
             (r_state == S_HOLD) ? ((out_valid && out_ready) ? S_NULL : S_HOLD) :
             (w_done ? S_IDLE : S_NULL);
  end

`ifdef NCL_BRIDGE_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_to;
  assign w_wd_fire = ((r_state == S_DATA) || (r_state == S_NULL)) && (r_wd == 32'(TIMEOUT_CYCLES - 1));
  assign timeout   = r_to;
  // watchdog counts time spent waiting on the adder, restarting at every state change
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      r_wd <= ((w_next != r_state) || !((r_state == S_DATA) || (r_state == S_NULL))) ? '0 : r_wd + 32'd1;
      r_to <= r_to | w_wd_fire;
    end
  end
`else
  assign w_wd_fire = 1'b0;
  assign timeout   = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // handshake, synchronizer, stability counter and result capture
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state   <= S_IDLE;
      r_rdy     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      r_rdy   <= 1'b1;
      r_s1    <= {cout_rail, sum_rail};
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : w_run;
      if (in_valid && in_ready) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_cin <= in_cin;
      end
      if ((r_state == S_DATA) && (w_next == S_HOLD)) begin
        out_sum   <= w_dec;
        out_cout  <= !r_s2[W-2];
        out_err   <= w_multi;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
